// File: rtl/spi_master_cmd_pkg.sv
// -----------------------------------------------------------------------------
// spi_master_pkg
// Shared definitions for the spi_master_cmd SPI initiator: command codes,
// FSM state encoding, frame/response widths and the frame builder.
// -----------------------------------------------------------------------------
package spi_master_pkg;

    localparam int FRAME_BITS = 11;
    localparam int RSP_BITS   = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        TX    = 3'd2,
        TURN  = 3'd3,
        RX    = 3'd4,
        HOLD  = 3'd5
    } state_e;

    // Frame layout, MSB first: routing bit (code[1]), code[1:0], data[7:0].
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [1:0] code,
                                                          input logic [7:0] data);
        return {code[1], code, data};
    endfunction

endpackage

// File: rtl/spi_master_cmd_if.sv
// -----------------------------------------------------------------------------
// spi_master_cmd_if
// Host-side command/response bundle of the SPI initiator.
//   cmd_valid / cmd_ready : command handshake (transfer when both high)
//   cmd_code [1:0]        : WR_ADDR / WR_DATA / RD_ADDR / RD_DATA
//   cmd_data [7:0]        : address or write data
//   rsp_valid             : one-cycle pulse, read byte available
//   rsp_data [7:0]        : last read byte
// Modports: master = host side, slave = spi_master_cmd side.
// -----------------------------------------------------------------------------
interface spi_master_cmd_if;
    import spi_master_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_code;
    logic [7:0]          cmd_data;
    logic                rsp_valid;
    logic [RSP_BITS-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_code, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_code, cmd_data,
        output cmd_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/spi_master_cmd_clk_gen.sv
// -----------------------------------------------------------------------------
// spi_clk_gen
// SCLK half-period divider. Counts CLK_DIV clk cycles per half period and
// flags the end of each half: rise marks the end of a low half (SCLK should
// go high), fall marks the end of a high half. clr forces the low half and a
// zero count so that the first rise comes exactly CLK_DIV cycles later.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance the divider
//   clr        : restart the divider at the beginning of a low half
//   rise, fall : single-cycle strobes
// -----------------------------------------------------------------------------
module spi_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic rise,
    output logic fall
);

    localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             high_q;
    logic             tick;

    assign tick = en && !clr && (cnt_q == CNT_LAST);
    assign rise = tick && !high_q;
    assign fall = tick && high_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            high_q <= 1'b0;
        end else if (clr) begin
            cnt_q  <= '0;
            high_q <= 1'b0;
        end else if (en) begin
            if (tick) begin
                cnt_q  <= '0;
                high_q <= !high_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_master_cmd.sv
// -----------------------------------------------------------------------------
// spi_master_cmd
// SPI mode-0 initiator driving the SPI-slave/single-port-RAM subsystem.
// Each accepted command is sent as an 11-bit frame (routing bit, code, data)
// MSB first; RD_DATA frames are followed by TURN_CYCLES idle SCLK periods and
// 8 SCLK periods in which the response byte is clocked in from miso.
// Parameters:
//   CLK_DIV     : SCLK half-period in clk cycles (>= 1)
//   TURN_CYCLES : idle SCLK periods before the read response (0..7)
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   host        : command/response interface (spi_master_cmd_if.slave)
//   ss_n, sclk, mosi, miso : SPI pins (CPOL=0, CPHA=0, active-low select)
//   seq_err     : only when SPI_MASTER_SEQ_CHECK_EN is defined; one-cycle
//                 pulse when RD_DATA is accepted without a preceding RD_ADDR
// Optional build macro: SPI_MASTER_SEQ_CHECK_EN
// -----------------------------------------------------------------------------
module spi_master_cmd
    import spi_master_pkg::*;
#(
    parameter int CLK_DIV     = 2,
    parameter int TURN_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    spi_master_cmd_if.slave host,
    output logic       ss_n,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
`ifdef SPI_MASTER_SEQ_CHECK_EN
    ,
    output logic       seq_err
`endif
);

    localparam logic [3:0] TX_LOAD   = 4'(FRAME_BITS - 1);
    localparam logic [3:0] RX_LOAD   = 4'(RSP_BITS - 1);
    localparam logic [3:0] TURN_LOAD = (TURN_CYCLES > 0) ? 4'(TURN_CYCLES - 1) : 4'd0;

    state_e                state_q, state_d;
    logic [1:0]            cmd_code_q;
    logic [3:0]            bit_cnt_q;
    logic [FRAME_BITS-1:0] tx_sr_q;
    logic [RSP_BITS-1:0]   rx_sr_q;
    logic [RSP_BITS-1:0]   rsp_data_q;
    logic                  rsp_valid_q;
    logic                  sclk_q;
    logic                  cmd_ready_int;
    logic                  accept;
    logic                  rise, fall;
    logic                  run_d;

    assign accept = host.cmd_valid && cmd_ready_int;
    // SCLK toggles only while the next state is one of the clocked phases.
    assign run_d  = (state_d == TX) || (state_d == TURN) || (state_d == RX);

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q != IDLE),
        .clr   (state_q == IDLE),
        .rise  (rise),
        .fall  (fall)
    );

    // ---- FSM state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- FSM next state ----
    // Phase ends are all aligned to rise strobes: a rise closes the low half
    // of the last period of a phase, and bit_cnt_q==0 marks that last period.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (host.cmd_valid) state_d = SETUP;
            SETUP: if (rise) state_d = TX;
            TX: begin
                if (rise && bit_cnt_q == 4'd0) begin
                    if (cmd_code_q == CMD_RD_DATA) begin
                        state_d = (TURN_CYCLES == 0) ? RX : TURN;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            TURN:  if (rise && bit_cnt_q == 4'd0) state_d = RX;
            RX:    if (rise && bit_cnt_q == 4'd0) state_d = HOLD;
            HOLD:  if (rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---- FSM outputs ----
    always_comb begin
        cmd_ready_int = 1'b0;
        ss_n          = 1'b0;
        mosi          = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready_int = 1'b1;
                ss_n          = 1'b1;
            end
            SETUP, TX: mosi = tx_sr_q[FRAME_BITS-1];
            HOLD:      ss_n = 1'b1;
            default: ;
        endcase
    end

    assign host.cmd_ready = cmd_ready_int;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_data  = rsp_data_q;
    assign sclk           = sclk_q;

    // ---- control: captured code, bit counter, SCLK, response ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_code_q  <= CMD_WR_ADDR;
            bit_cnt_q   <= 4'd0;
            sclk_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            if (accept) cmd_code_q <= host.cmd_code;

            if (state_d != state_q) begin
                case (state_d)
                    TX:      bit_cnt_q <= TX_LOAD;
                    TURN:    bit_cnt_q <= TURN_LOAD;
                    RX:      bit_cnt_q <= RX_LOAD;
                    default: bit_cnt_q <= 4'd0;
                endcase
            end else if (rise && bit_cnt_q != 4'd0) begin
                bit_cnt_q <= bit_cnt_q - 4'd1;
            end

            if (rise && run_d) begin
                sclk_q <= 1'b1;
            end else if (fall) begin
                sclk_q <= 1'b0;
            end

            // Only an RD_DATA frame reaches HOLD from RX.
            rsp_valid_q <= (state_q == RX) && (state_d == HOLD);
            if ((state_q == RX) && (state_d == HOLD)) begin
                rsp_data_q <= rx_sr_q;
            end
        end
    end

    // ---- datapath: transmit and receive shift registers ----
    // Zeros shift in behind the frame; mosi is gated by state outside TX.
    // miso is taken on the same edge that drives sclk high in RX, i.e. from
    // data the slave set up on the preceding fall.
    always_ff @(posedge clk) begin
        if (accept) begin
            tx_sr_q <= build_frame(host.cmd_code, host.cmd_data);
        end else if (fall && state_q == TX) begin
            tx_sr_q <= {tx_sr_q[FRAME_BITS-2:0], 1'b0};
        end

        if (rise && state_d == RX) begin
            rx_sr_q <= {rx_sr_q[RSP_BITS-2:0], miso};
        end
    end

`ifdef SPI_MASTER_SEQ_CHECK_EN
    logic rd_armed_q;
    logic seq_err_q;
    logic frame_done;

    assign frame_done = (state_q != HOLD) && (state_d == HOLD);
    assign seq_err    = seq_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_armed_q <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            seq_err_q <= accept && (host.cmd_code == CMD_RD_DATA) && !rd_armed_q;
            if (frame_done) begin
                if (cmd_code_q == CMD_RD_ADDR) begin
                    rd_armed_q <= 1'b1;
                end else if (cmd_code_q == CMD_RD_DATA) begin
                    rd_armed_q <= 1'b0;
                end
            end
        end
    end
`endif

endmodule
